vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator. Successor to the fixed 640x480 hcount/vcount/sync trio.
- Produces horizontal and vertical counters, sync pulses with selectable polarity, and a visible-area flag with pixel coordinates.
- Also produces line, frame and vsync-edge strobes, plus a wrapping frame counter.
- Feeds the pixel/text pipeline and vga_output. Any mode (640x480, 800x600 at divided clock, small bench modes) is set purely by parameters.

---
 rtl/vga_timing_gen.sv | 110 +++++++++++
 tb/tb_vga_timing_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters, region decode,
// registered sync/visible/coordinate outputs, line/frame/vsync strobes.
module vga_timing_gen #(
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter bit H_POL   = 1'b0,
  parameter bit V_POL   = 1'b0,
  parameter int CNT_W   = 12,
  parameter int FRAME_W = 10
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               pixEn,
  output logic               hSync,
  output logic               vSync,
  output logic               vis,
  output logic [CNT_W-1:0]   pixX,
  output logic [CNT_W-1:0]   pixY,
  output logic               lineEnd,
  output logic               frameEnd,
  output logic               vSyncEnd,
  output logic [FRAME_W-1:0] frameCount
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // A zero-length region or a total that cannot be counted is a mode error.
  if (H_VIS <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_VIS <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 ||
      CNT_W <= 0 || FRAME_W <= 0) begin : gZeroParam
    $error("vga_timing_gen: every timing/width parameter must be non-zero");
  end
  if (longint'(H_TOTAL) > (longint'(1) << CNT_W) ||
      longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : gTotalTooBig
    $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] H_VIS_C    = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_VIS_C    = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_VIS + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_LST = CNT_W'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] hCnt, vCnt;
  logic [CNT_W-1:0] hCntNext, vCntNext;
  logic             hWrap, vWrap;
  logic             hActive, vActive, visNow;

  // Region decode of the present counter state; registered below so every
  // output is aligned to the same (hCnt, vCnt) sample.
  always_comb begin
    hWrap    = (hCnt == H_LAST);
    vWrap    = (vCnt == V_LAST);
    hCntNext = hWrap ? '0 : hCnt + CNT_W'(1);
    vCntNext = vCnt;
    if (hWrap) begin
      vCntNext = vWrap ? '0 : vCnt + CNT_W'(1);
    end
    hActive  = (hCnt >= H_SYNC_BEG) && (hCnt < H_SYNC_END);
    vActive  = (vCnt >= V_SYNC_BEG) && (vCnt < V_SYNC_END);
    visNow   = (hCnt < H_VIS_C) && (vCnt < V_VIS_C);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      hCnt       <= '0;
      vCnt       <= '0;
      pixX       <= '0;
      pixY       <= '0;
      vis        <= 1'b0;
      hSync      <= ~H_POL;
      vSync      <= ~V_POL;
      lineEnd    <= 1'b0;
      frameEnd   <= 1'b0;
      vSyncEnd   <= 1'b0;
      frameCount <= '0;
    end else if (pixEn) begin
      hCnt     <= hCntNext;
      vCnt     <= vCntNext;
      pixX     <= hCnt;
      pixY     <= vCnt;
      vis      <= visNow;
      hSync    <= hActive ? H_POL : ~H_POL;
      vSync    <= vActive ? V_POL : ~V_POL;
      lineEnd  <= hWrap;
      frameEnd <= hWrap && vWrap;
      vSyncEnd <= hWrap && (vCnt == V_SYNC_LST);
      if (hWrap && vWrap) begin
        frameCount <= frameCount + FRAME_W'(1);
      end
    end else begin
      // Stalled pixel: hold everything, but strobes must not repeat.
      lineEnd  <= 1'b0;
      frameEnd <= 1'b0;
      vSyncEnd <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a small 16x8 mode: linear-position reference
// model, two polarities, directed scan phases plus randomized pixEn/reset.
module tb_vga_timing_gen;

  localparam int HV = 8, HF = 2, HS = 3, HB = 3;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic pixEn = 1'b0;

  logic hSync0, vSync0, vis0, lineEnd0, frameEnd0, vSyncEnd0;
  logic [11:0] pixX0, pixY0;
  logic [1:0]  frameCount0;
  logic hSync1, vSync1, vis1, lineEnd1, frameEnd1, vSyncEnd1;
  logic [11:0] pixX1, pixY1;
  logic [9:0]  frameCount1;

  vga_timing_gen #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0), .CNT_W(12), .FRAME_W(2)
  ) dut (
    .clk(clk), .nrst(nrst), .pixEn(pixEn),
    .hSync(hSync0), .vSync(vSync0), .vis(vis0),
    .pixX(pixX0), .pixY(pixY0),
    .lineEnd(lineEnd0), .frameEnd(frameEnd0), .vSyncEnd(vSyncEnd0),
    .frameCount(frameCount0)
  );

  vga_timing_gen #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b1), .V_POL(1'b1), .CNT_W(12), .FRAME_W(10)
  ) dutPol (
    .clk(clk), .nrst(nrst), .pixEn(pixEn),
    .hSync(hSync1), .vSync(vSync1), .vis(vis1),
    .pixX(pixX1), .pixY(pixY1),
    .lineEnd(lineEnd1), .frameEnd(frameEnd1), .vSyncEnd(vSyncEnd1),
    .frameCount(frameCount1)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: a linear pixel index within the frame plus frame tally.
  int pos = 0, frames = 0, ex = 0, ey = 0;
  bit eVis = 0, eHAct = 0, eVAct = 0, eLe = 0, eFe = 0, eVse = 0;

  int tVis, tHsLow, tVsLow, tLe, tFe, tVse, tBadPos;
  int fcSeq[$];

  task automatic modelStep(input bit rst, input bit en);
    if (!rst) begin
      pos = 0; frames = 0; ex = 0; ey = 0;
      eVis = 0; eHAct = 0; eVAct = 0; eLe = 0; eFe = 0; eVse = 0;
    end else if (!en) begin
      eLe = 0; eFe = 0; eVse = 0;
    end else begin
      ex    = pos % HT;
      ey    = pos / HT;
      eVis  = (ex < HV) && (ey < VV);
      eHAct = (ex >= HV + HF) && (ex < HV + HF + HS);
      eVAct = (ey >= VV + VF) && (ey < VV + VF + VS);
      eLe   = (ex == HT - 1);
      eFe   = (pos == HT * VT - 1);
      eVse  = eLe && (ey == VV + VF + VS - 1);
      if (eFe) frames++;
      pos = (pos + 1) % (HT * VT);
    end
  endtask

  task automatic checkDut(input string name, input bit pol, input int fcMod,
                          input logic hs, input logic vs, input logic vi,
                          input logic [11:0] x, input logic [11:0] y,
                          input logic le, input logic fe, input logic vse,
                          input int fc);
    logic expHs, expVs;
    int   expFc;
    expHs = eHAct ? pol : ~pol;
    expVs = eVAct ? pol : ~pol;
    expFc = frames % fcMod;
    nChecks++;
    if (hs !== expHs || vs !== expVs || vi !== eVis || x !== 12'(ex) ||
        y !== 12'(ey) || le !== eLe || fe !== eFe || vse !== eVse || fc != expFc) begin
      nFails++;
      $display("[TB] FAIL %s @%0t: got hs=%b vs=%b vis=%b x=%0d y=%0d le=%b fe=%b vse=%b fc=%0d; want hs=%b vs=%b vis=%b x=%0d y=%0d le=%b fe=%b vse=%b fc=%0d",
               name, $time, hs, vs, vi, x, y, le, fe, vse, fc,
               expHs, expVs, eVis, ex, ey, eLe, eFe, eVse, expFc);
    end
  endtask

  task automatic checkOutput();
    checkDut("outputsPol0", 1'b0, 4, hSync0, vSync0, vis0, pixX0, pixY0,
             lineEnd0, frameEnd0, vSyncEnd0, int'(frameCount0));
    checkDut("outputsPol1", 1'b1, 1024, hSync1, vSync1, vis1, pixX1, pixY1,
             lineEnd1, frameEnd1, vSyncEnd1, int'(frameCount1));
    if (vis0) tVis++;
    if (!hSync0) tHsLow++;
    if (!vSync0) tVsLow++;
    if (lineEnd0) tLe++;
    if (frameEnd0) begin
      tFe++;
      fcSeq.push_back(int'(frameCount0));
      if (pixX0 != 12'd15 || pixY0 != 12'd7) tBadPos++;
    end
    if (vSyncEnd0) begin
      tVse++;
      if (pixX0 != 12'd15 || pixY0 != 12'd6) tBadPos++;
    end
  endtask

  task automatic checkLiteral(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic resetTallies();
    tVis = 0; tHsLow = 0; tVsLow = 0; tLe = 0; tFe = 0; tVse = 0; tBadPos = 0;
    fcSeq.delete();
  endtask

  task automatic applyStimulus(input bit rst, input bit en);
    nrst  = rst;
    pixEn = en;
    @(posedge clk);
    modelStep(rst, en);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    bit found;
    resetTallies();
    $display("[TB] reset and one full frame with pixEn held high");
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    resetTallies();
    for (int i = 0; i < 128; i++) applyStimulus(1'b1, 1'b1);
    checkLiteral("visCycles", tVis, 32);
    checkLiteral("hSyncLowCycles", tHsLow, 24);
    checkLiteral("vSyncLowCycles", tVsLow, 32);
    checkLiteral("lineEndCount", tLe, 8);
    checkLiteral("frameEndCount", tFe, 1);
    checkLiteral("frameCountAfterFrame", int'(frameCount0), 1);
    checkLiteral("strobePosition", tBadPos, 0);

    $display("[TB] pixEn toggling for 256 cycles");
    resetTallies();
    for (int i = 0; i < 256; i++) applyStimulus(1'b1, bit'(i % 2 == 0));
    checkLiteral("toggleLineEnds", tLe, 8);
    checkLiteral("toggleFrameEnds", tFe, 1);

    $display("[TB] reset at pixX=6 pixY=2");
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      applyStimulus(1'b1, bit'($urandom_range(0, 1)));
      if (ex == 6 && ey == 2) found = 1'b1;
    end
    checkLiteral("reachedResetPoint", int'(found), 1);
    applyStimulus(1'b0, 1'b1);
    checkLiteral("frameCountAfterReset", int'(frameCount0), 0);

    $display("[TB] five frames with 2-bit frame counter");
    resetTallies();
    for (int i = 0; i < 5 * HT * VT; i++) applyStimulus(1'b1, 1'b1);
    checkLiteral("fiveFrameEnds", tFe, 5);
    checkLiteral("fiveVSyncEnds", tVse, 5);
    checkLiteral("strobePositions5", tBadPos, 0);
    if (fcSeq.size() == 5) begin
      checkLiteral("fcSeq0", fcSeq[0], 1);
      checkLiteral("fcSeq1", fcSeq[1], 2);
      checkLiteral("fcSeq2", fcSeq[2], 3);
      checkLiteral("fcSeq3", fcSeq[3], 0);
      checkLiteral("fcSeq4", fcSeq[4], 1);
    end

    $display("[TB] randomized pixEn with occasional reset");
    for (int i = 0; i < 3000; i++)
      applyStimulus(bit'($urandom_range(0, 299) != 0), bit'($urandom_range(0, 3) != 0));

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
